// File: rtl/odd_even_merge_pkg.sv
// Shared types and helpers for the iterative odd-even merge sorter.
// Keys are handled at a fixed wide width inside helpers and narrowed by the caller.
package odd_even_merge_pkg;

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  localparam int STAGE_W = 4;
  typedef logic [STAGE_W-1:0] stage_t;

  localparam int STEP_W = 6;
  typedef logic [STEP_W-1:0] step_t;

  localparam int MAX_KEY_W = 64;
  typedef logic [MAX_KEY_W-1:0] wide_key_t;

  function automatic int num_stages(input int log_input);
    return log_input * (log_input + 1) / 2;
  endfunction

  // True when index a is the lower element of a compare-exchange pair in stage (p_log, k_log).
  function automatic logic cx_active(input int a, input int p_log, input int k_log, input int n);
    int k;
    int j0;
    k  = 1 << k_log;
    j0 = (k_log == p_log) ? 0 : k;
    if (a < j0 || a + k >= n) return 1'b0;
    if (((a - j0) & (2 * k - 1)) >= k) return 1'b0;
    return ((a >> (p_log + 1)) == ((a + k) >> (p_log + 1)));
  endfunction

  function automatic wide_key_t sentinel(input logic dir, input logic is_signed, input int width);
    wide_key_t ones;
    ones = (width >= MAX_KEY_W) ? '1 : ((wide_key_t'(1) << width) - wide_key_t'(1));
    if (!dir) return is_signed ? (ones >> 1) : ones;
    return is_signed ? (wide_key_t'(1) << (width - 1)) : '0;
  endfunction

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  function automatic logic key_lt(input wide_key_t a, input wide_key_t b,
                                  input logic is_signed, input int width);
    wide_key_t flip;
    flip = is_signed ? (wide_key_t'(1) << (width - 1)) : '0;
    return ((a ^ flip) < (b ^ flip));
  endfunction

endpackage

// File: rtl/odd_even_merge_iter_sorter_cx_layer.sv
// One Batcher network stage: every element picks its partner for the current (p_log, k_log)
// and keeps min or max depending on its side of the pair and the sort direction.
module oem_cx_layer
  import odd_even_merge_pkg::*;
#(
  parameter int LOG_INPUT  = 7,
  parameter int DATA_WIDTH = 32,
  parameter int SIGNED     = 0
) (
  input  logic [(2**LOG_INPUT)*DATA_WIDTH-1:0] keys_in,
  input  stage_t                               p_log,
  input  stage_t                               k_log,
  input  logic                                 dir,
  output logic [(2**LOG_INPUT)*DATA_WIDTH-1:0] keys_out
);

  localparam int N = 2 ** LOG_INPUT;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_elem
      logic [DATA_WIDTH-1:0] res;

      always_comb begin
        int k;
        logic [DATA_WIDTH-1:0] a_key;
        logic [DATA_WIDTH-1:0] b_key;
        logic swap;
        res   = keys_in[gi*DATA_WIDTH +: DATA_WIDTH];
        k     = 0;
        a_key = '0;
        b_key = '0;
        swap  = 1'b0;
        for (int kl = 0; kl < LOG_INPUT; kl++) begin
          if (stage_t'(kl) == k_log) begin
            k = 1 << kl;
            if (gi + k < N && cx_active(gi, int'(p_log), kl, N)) begin
              a_key = keys_in[gi*DATA_WIDTH +: DATA_WIDTH];
              b_key = keys_in[(gi + k)*DATA_WIDTH +: DATA_WIDTH];
              swap  = dir ? key_lt(MAX_KEY_W'(a_key), MAX_KEY_W'(b_key), SIGNED != 0, DATA_WIDTH)
                          : key_lt(MAX_KEY_W'(b_key), MAX_KEY_W'(a_key), SIGNED != 0, DATA_WIDTH);
              res   = swap ? b_key : a_key;
            end else if (gi >= k && cx_active(gi - k, int'(p_log), kl, N)) begin
              a_key = keys_in[(gi - k)*DATA_WIDTH +: DATA_WIDTH];
              b_key = keys_in[gi*DATA_WIDTH +: DATA_WIDTH];
              swap  = dir ? key_lt(MAX_KEY_W'(a_key), MAX_KEY_W'(b_key), SIGNED != 0, DATA_WIDTH)
                          : key_lt(MAX_KEY_W'(b_key), MAX_KEY_W'(a_key), SIGNED != 0, DATA_WIDTH);
              res   = swap ? a_key : b_key;
            end
          end
        end
      end

      assign keys_out[gi*DATA_WIDTH +: DATA_WIDTH] = res;
    end
  endgenerate

endmodule

// File: rtl/odd_even_merge_iter_sorter.sv
// Streaming Batcher odd-even merge sorter: serial load, one network stage per cycle,
// serial drain through a registered output stage.
module odd_even_merge_iter_sorter
  import odd_even_merge_pkg::*;
#(
  parameter int LOG_INPUT  = 7,
  parameter int DATA_WIDTH = 32,
  parameter int SIGNED     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  input  logic                  desc,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
);

  localparam int N = 2 ** LOG_INPUT;
  localparam int S = num_stages(LOG_INPUT);

  typedef logic [LOG_INPUT-1:0] idx_t;
  typedef logic [LOG_INPUT:0]   cnt_t;

  state_t                state_reg;
  idx_t                  cnt_reg;
  cnt_t                  n_reg;
  cnt_t                  rd_idx_reg;
  logic                  dir_reg;
  stage_t                p_log_reg;
  stage_t                k_log_reg;
  step_t                 step_reg;
  logic                  m_valid_reg;
  logic                  m_last_reg;
  logic [DATA_WIDTH-1:0] m_data_reg;
  logic [DATA_WIDTH-1:0] keys_reg [N];

  logic [N*DATA_WIDTH-1:0] cur_flat;
  logic [N*DATA_WIDTH-1:0] nxt_flat;

  logic                  s_fire;
  logic                  frame_end;
  logic                  load_dir;
  logic [DATA_WIDTH-1:0] sent_key;

  assign s_ready   = (state_reg == LOAD) && !rst;
  assign s_fire    = s_valid && s_ready;
  assign frame_end = s_fire && (s_last || cnt_reg == idx_t'(N - 1));
  assign load_dir  = (cnt_reg == '0) ? desc : dir_reg;
  assign sent_key  = DATA_WIDTH'(sentinel(load_dir, SIGNED != 0, DATA_WIDTH));

  assign m_valid = m_valid_reg;
  assign m_data  = m_data_reg;
  assign m_last  = m_last_reg;
  assign busy    = (state_reg != LOAD);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_flat
      assign cur_flat[gi*DATA_WIDTH +: DATA_WIDTH] = keys_reg[gi];
    end
  endgenerate

  oem_cx_layer #(
    .LOG_INPUT (LOG_INPUT),
    .DATA_WIDTH(DATA_WIDTH),
    .SIGNED    (SIGNED)
  ) u_layer (
    .keys_in (cur_flat),
    .p_log   (p_log_reg),
    .k_log   (k_log_reg),
    .dir     (dir_reg),
    .keys_out(nxt_flat)
  );

  // Slots past the last loaded key get the sentinel so they sink to the tail.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst) begin
        if (state_reg == SORT) begin
          keys_reg[i] <= nxt_flat[i*DATA_WIDTH +: DATA_WIDTH];
        end else if (s_fire) begin
          if (cnt_reg == idx_t'(i)) begin
            keys_reg[i] <= s_data;
          end else if (frame_end && cnt_reg < idx_t'(i)) begin
            keys_reg[i] <= sent_key;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= LOAD;
      cnt_reg     <= '0;
      n_reg       <= '0;
      rd_idx_reg  <= '0;
      dir_reg     <= 1'b0;
      p_log_reg   <= '0;
      k_log_reg   <= '0;
      step_reg    <= '0;
      m_valid_reg <= 1'b0;
      m_last_reg  <= 1'b0;
      m_data_reg  <= '0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (s_fire) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == '0) dir_reg <= desc;
            if (frame_end) begin
              n_reg     <= {1'b0, cnt_reg} + 1'b1;
              p_log_reg <= '0;
              k_log_reg <= '0;
              step_reg  <= '0;
              state_reg <= SORT;
            end
          end
        end
        SORT: begin
          if (step_reg == step_t'(S - 1)) begin
            rd_idx_reg <= '0;
            state_reg  <= DRAIN;
          end else begin
            step_reg <= step_reg + 1'b1;
            if (k_log_reg == '0) begin
              p_log_reg <= p_log_reg + 1'b1;
              k_log_reg <= p_log_reg + 1'b1;
            end else begin
              k_log_reg <= k_log_reg - 1'b1;
            end
          end
        end
        DRAIN: begin
          // The output register refills whenever it is empty or being consumed.
          if (!m_valid_reg || m_ready) begin
            if (m_valid_reg && m_last_reg) begin
              m_valid_reg <= 1'b0;
              m_last_reg  <= 1'b0;
              m_data_reg  <= '0;
              cnt_reg     <= '0;
              state_reg   <= LOAD;
            end else begin
              m_valid_reg <= 1'b1;
              m_data_reg  <= keys_reg[rd_idx_reg[LOG_INPUT-1:0]];
              m_last_reg  <= (rd_idx_reg + 1'b1 == n_reg);
              rd_idx_reg  <= rd_idx_reg + 1'b1;
            end
          end
        end
        default: state_reg <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_odd_even_merge_iter_sorter.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_odd_even_merge_iter_sorter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]      s_valid, s_last, desc, s_ready, m_valid, m_last, busy;
  logic [1:0]      m_ready = 2'b00;
  logic [1:0][7:0] s_data, m_data;

  odd_even_merge_iter_sorter #(.LOG_INPUT(2), .DATA_WIDTH(8), .SIGNED(0)) u0 (
    .clk(clk), .rst(rst), .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]),
    .s_last(s_last[0]), .desc(desc[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]),
    .m_data(m_data[0]), .m_last(m_last[0]), .busy(busy[0]));

  odd_even_merge_iter_sorter #(.LOG_INPUT(7), .DATA_WIDTH(8), .SIGNED(1)) u1 (
    .clk(clk), .rst(rst), .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]),
    .s_last(s_last[1]), .desc(desc[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]),
    .m_data(m_data[1]), .m_last(m_last[1]), .busy(busy[1]));

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int t_last = 0;
  logic [7:0] fr [128];
  logic [7:0] ex [128];
  logic [1:0]      stalled = 2'b00;
  logic [1:0][7:0] held_data;
  logic [1:0]      held_last;

  task automatic check(input string name, input int act, input int exp_v);
    vec_cnt++;
    if (act != exp_v) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       m_ready = 2'b11;
      1:       m_ready = 2'($urandom_range(0, 3));
      default: m_ready = 2'b00;
    endcase
  end

  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        stalled[d] = 1'b0;
      end else begin
        if (stalled[d]) begin
          check("stall_valid", int'(m_valid[d]), 1);
          check("stall_data", int'(m_data[d]), int'(held_data[d]));
          check("stall_last", int'(m_last[d]), int'(held_last[d]));
        end
        if (!m_valid[d]) begin
          check("idle_data_zero", int'(m_data[d]), 0);
        end else if (m_ready[d]) begin
          if (exp_q.size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL unexpected_beat: dut %0d got %0d, expected no beat", d, m_data[d]);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            check("out_data", int'(m_data[d]), int'(e.data));
            check("out_last", int'(m_last[d]), int'(e.last));
            $display("beat dut%0d data=%0d last=%0d", d, m_data[d], m_last[d]);
          end
        end
        stalled[d]   = m_valid[d] && !m_ready[d];
        held_data[d] = m_data[d];
        held_last[d] = m_last[d];
      end
    end
  end

  task automatic push_exp(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({ex[i], i == n - 1});
  endtask

  task automatic send_frame(input int d, input int n, input logic dsc, input logic use_last);
    for (int i = 0; i < n; i++) begin
      int guard;
      s_valid[d] = 1'b1;
      s_data[d]  = fr[i];
      s_last[d]  = use_last && (i == n - 1);
      desc[d]    = dsc;
      guard = 0;
      forever begin
        @(negedge clk);
        if (s_ready[d]) break;
        guard++;
        if (guard > 5000) begin
          $display("FAIL s_ready_timeout: dut %0d never ready, expected ready", d);
          $fatal(1, "input stalled");
        end
      end
      @(posedge clk);
      #1;
    end
    s_valid[d] = 1'b0;
    s_last[d]  = 1'b0;
    t_last     = cyc;
    $display("frame dut%0d n=%0d desc=%0d sent", d, n, dsc);
  endtask

  task automatic wait_valid(input int d, output int lat);
    lat = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (m_valid[d]) begin
        lat = cyc - t_last;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int d);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && s_ready[d] && !m_valid[d]) break;
    end
    check("drain_complete", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    check("rst_s_ready_low", int'(s_ready[0]), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_m_valid", int'(m_valid[0]), 0);
    check("post_rst_s_ready", int'(s_ready[0]), 1);
    check("post_rst_busy", int'(busy[0]), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic ref_sort(input int n, input logic dsc, input logic sgn);
    int arr [128];
    for (int i = 0; i < n; i++) arr[i] = sgn ? int'($signed(fr[i])) : int'(fr[i]);
    for (int i = 1; i < n; i++) begin
      int v;
      int j;
      v = arr[i];
      j = i - 1;
      while (j >= 0 && arr[j] > v) begin
        arr[j + 1] = arr[j];
        j--;
      end
      arr[j + 1] = v;
    end
    for (int i = 0; i < n; i++) ex[i] = 8'(dsc ? arr[n - 1 - i] : arr[i]);
  endtask

  initial begin
    int lat;
    s_valid = '0;
    s_last  = '0;
    desc    = '0;
    s_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_s_ready", int'(s_ready), 0);
    check("reset_m_valid", int'(m_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_m_data", int'(m_data[0]), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("release_s_ready", int'(s_ready[0]), 1);
    @(posedge clk);
    #1;

    // Full frame, ascending, with latency S+1 = 4
    fr[0:3] = '{8'd3, 8'd1, 8'd4, 8'd2};
    ex[0:3] = '{8'd1, 8'd2, 8'd3, 8'd4};
    push_exp(4);
    send_frame(0, 4, 1'b0, 1'b1);
    wait_valid(0, lat);
    check("latency_l2", lat, 4);
    wait_idle(0);

    // Fourth beat without s_last still closes the frame
    fr[0:3] = '{8'd4, 8'd3, 8'd2, 8'd1};
    ex[0:3] = '{8'd1, 8'd2, 8'd3, 8'd4};
    push_exp(4);
    send_frame(0, 4, 1'b0, 1'b0);
    @(negedge clk);
    check("forced_end_not_ready", int'(s_ready[0]), 0);
    @(posedge clk);
    #1;
    wait_idle(0);

    fr[0:2] = '{8'd9, 8'd0, 8'd5};
    ex[0:2] = '{8'd0, 8'd5, 8'd9};
    push_exp(3);
    send_frame(0, 3, 1'b0, 1'b1);
    wait_idle(0);
    ex[0:2] = '{8'd9, 8'd5, 8'd0};
    push_exp(3);
    send_frame(0, 3, 1'b1, 1'b1);
    wait_idle(0);

    // Keys equal to the sentinel
    fr[0:2] = '{8'd255, 8'd255, 8'd1};
    ex[0:2] = '{8'd1, 8'd255, 8'd255};
    push_exp(3);
    send_frame(0, 3, 1'b0, 1'b1);
    wait_idle(0);

    rdy_mode = 1;
    fr[0] = 8'd7;
    ex[0] = 8'd7;
    push_exp(1);
    send_frame(0, 1, 1'b0, 1'b1);
    @(negedge clk);
    check("single_busy", int'(busy[0]), 1);
    @(posedge clk);
    #1;
    wait_valid(0, lat);
    check("latency_single", lat, 4);
    wait_idle(0);

    fr[0:2] = '{8'd9, 8'd0, 8'd5};
    ex[0:2] = '{8'd9, 8'd5, 8'd0};
    push_exp(3);
    send_frame(0, 3, 1'b1, 1'b1);
    wait_idle(0);

    // Abort in SORT, then in DRAIN; neither frame may emit anything
    fr[0:3] = '{8'd5, 8'd6, 8'd7, 8'd8};
    send_frame(0, 4, 1'b0, 1'b1);
    pulse_reset();
    rdy_mode = 2;
    send_frame(0, 4, 1'b0, 1'b1);
    wait_valid(0, lat);
    check("latency_before_abort", lat, 4);
    pulse_reset();
    rdy_mode = 1;
    repeat (10) @(posedge clk);
    #1;
    fr[0:3] = '{8'd2, 8'd2, 8'd1, 8'd3};
    ex[0:3] = '{8'd1, 8'd2, 8'd2, 8'd3};
    push_exp(4);
    send_frame(0, 4, 1'b0, 1'b1);
    wait_idle(0);

    // Signed keys on the 128-entry instance: latency 28+1
    fr[0:3] = '{8'hFF, 8'h02, 8'h80, 8'h7F};
    ex[0:3] = '{8'h80, 8'hFF, 8'h02, 8'h7F};
    push_exp(4);
    send_frame(1, 4, 1'b0, 1'b1);
    wait_valid(1, lat);
    check("latency_l7", lat, 29);
    wait_idle(1);

    for (int f = 0; f < 6; f++) begin
      int n;
      logic dsc;
      n   = (f == 0) ? 128 : int'($urandom_range(1, 128));
      dsc = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) fr[i] = 8'($urandom_range(0, 255));
      ref_sort(n, dsc, 1'b1);
      push_exp(n);
      send_frame(1, n, dsc, 1'b1);
    end
    wait_idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time %0t, expected completion earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
